// File: rtl/mips_mc_controller_pkg.sv
// ============================================================================
// mips_mc_controller_pkg : states, ALU codes, opcodes/functs and mux selects
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_JAL     = 4'd13,
    S_TRAP    = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_FUNCT = 3'd2,
    ALUOP_OR    = 3'd3,
    ALUOP_SLT   = 3'd4,
    ALUOP_SLTU  = 3'd5
  } aluop_e;

  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_SLTU = 4'b1111;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [5:0] c_FN_JR    = 6'b001000;
  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;
  localparam logic [5:0] c_FN_SLTU  = 6'b101011;

  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] c_PCSRC_REGA   = 2'b11;

  localparam logic [1:0] c_SRCB_REGB   = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
  localparam logic [1:0] c_SRCB_IMM    = 2'b10;
  localparam logic [1:0] c_SRCB_IMMSL2 = 2'b11;

  function automatic logic is_alu_funct(input logic [5:0] f);
    case (f)
      c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU,
      c_FN_AND, c_FN_OR, c_FN_SLT, c_FN_SLTU: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic is_final(input state_e s);
    case (s)
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_IMMWB,
      S_BRANCH, S_JUMP, S_JR, S_JAL: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_controller_aludec.sv
// ============================================================================
// mips_mc_controller_aludec : ALU-op class + funct -> 4-bit ALU control
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_mc_controller_aludec
  import mips_mc_controller_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alucontrol_o
);

  always_comb begin
    alucontrol_o = c_ALU_ADD;
    case (aluop_i)
      ALUOP_ADD:  alucontrol_o = c_ALU_ADD;
      ALUOP_SUB:  alucontrol_o = c_ALU_SUB;
      ALUOP_OR:   alucontrol_o = c_ALU_OR;
      ALUOP_SLT:  alucontrol_o = c_ALU_SLT;
      ALUOP_SLTU: alucontrol_o = c_ALU_SLTU;
      ALUOP_FUNCT: begin
        case (funct_i)
          c_FN_SUB, c_FN_SUBU: alucontrol_o = c_ALU_SUB;
          c_FN_AND:            alucontrol_o = c_ALU_AND;
          c_FN_OR:             alucontrol_o = c_ALU_OR;
          c_FN_SLT:            alucontrol_o = c_ALU_SLT;
          c_FN_SLTU:           alucontrol_o = c_ALU_SLTU;
          default:             alucontrol_o = c_ALU_ADD;
        endcase
      end
      default:    alucontrol_o = c_ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// ============================================================================
// mips_mc_controller : multicycle MIPS control FSM with req/ready memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memready,
  output logic             memreq,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       alucontrol,
  output logic             signext,
  output logic             shiftl16,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             pctoreg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  state_e             dec_state;
  state_e             illegal_tgt;
  aluop_e             aluop;
  logic               retire;
  logic [CNT_W-1:0]   instret_q;

  generate
    if (TRAP_ON_ILLEGAL) begin : g_trap
      assign illegal_tgt = S_TRAP;
    end else begin : g_nop
      assign illegal_tgt = S_FETCH;
    end
  endgenerate

  always_comb begin
    dec_state = illegal_tgt;
    case (op)
      c_OP_RTYPE: begin
        if (funct == c_FN_JR)         dec_state = S_JR;
        else if (is_alu_funct(funct)) dec_state = S_RTYPEEX;
        else                          dec_state = illegal_tgt;
      end
      c_OP_LW, c_OP_SW:               dec_state = S_MEMADR;
      c_OP_BEQ, c_OP_BNE:             dec_state = S_BRANCH;
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI,
      c_OP_SLTIU, c_OP_ORI, c_OP_LUI: dec_state = S_IMMEX;
      c_OP_J:                         dec_state = S_JUMP;
      c_OP_JAL:                       dec_state = S_JAL;
      default:                        dec_state = illegal_tgt;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    memreq   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    pcsrc    = c_PCSRC_ALU;
    alusrca  = 1'b0;
    alusrcb  = c_SRCB_REGB;
    aluop    = ALUOP_ADD;
    signext  = 1'b0;
    shiftl16 = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pctoreg  = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq  = 1'b1;
        alusrcb = c_SRCB_FOUR;
        if (memready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = c_SRCB_IMMSL2;
        signext = 1'b1;
        state_d = dec_state;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = c_SRCB_IMM;
        signext = 1'b1;
        state_d = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (memready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (memready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      // ALU selects held so alucontrol stays meaningful during write-back.
      S_RTYPEWB: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_FUNCT;
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = c_SRCB_IMM;
        case (op)
          c_OP_SLTI:  begin aluop = ALUOP_SLT;  signext = 1'b1; end
          c_OP_SLTIU: begin aluop = ALUOP_SLTU; signext = 1'b1; end
          c_OP_ORI:   begin aluop = ALUOP_OR;   signext = 1'b0; end
          c_OP_LUI:   begin aluop = ALUOP_ADD;  shiftl16 = 1'b1; end
          default:    begin aluop = ALUOP_ADD;  signext = 1'b1; end
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = c_PCSRC_ALUOUT;
        pcen    = (op == c_OP_BEQ) ? zero : ~zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = c_PCSRC_JUMP;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pcsrc   = c_PCSRC_REGA;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pcsrc    = c_PCSRC_JUMP;
        pcen     = 1'b1;
        regwrite = 1'b1;
        pctoreg  = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase

    retire = is_final(state_q) && (state_d == S_FETCH);

    // Reset aborts whatever is in flight within the same cycle.
    if (reset) begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + c_CNT_ONE;
    end
  end

  assign instret = instret_q;

  mips_mc_controller_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ============================================================================
// tb_mips_mc_controller : directed per-cycle scoreboard bench for the controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_mc_controller;

  // Narrow counter so the wrap-around is reached within the directed sequence.
  localparam int CNT_W = 4;

  localparam int B_ILLEGAL  = 0;
  localparam int B_PCTOREG  = 1;
  localparam int B_MEMTOREG = 2;
  localparam int B_REGDST   = 3;
  localparam int B_REGWRITE = 4;
  localparam int B_SHIFTL16 = 5;
  localparam int B_SIGNEXT  = 6;
  localparam int B_ALUCTL   = 7;
  localparam int B_ALUSRCB  = 11;
  localparam int B_ALUSRCA  = 13;
  localparam int B_PCSRC    = 14;
  localparam int B_PCEN     = 16;
  localparam int B_IRWRITE  = 17;
  localparam int B_MEMWRITE = 18;
  localparam int B_IORD     = 19;
  localparam int B_MEMREQ   = 20;

  logic clk = 1'b0;
  logic reset, zero, memready;
  logic [5:0] op, funct;
  logic memreq, iord, memwrite, irwrite, pcen, alusrca;
  logic signext, shiftl16, regwrite, regdst, memtoreg, pctoreg, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] alucontrol;
  logic [CNT_W-1:0] instret;
  logic [20:0] obs;

  always #5 clk = ~clk;

  mips_mc_controller #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .memreq(memreq), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .signext(signext),
    .shiftl16(shiftl16), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .pctoreg(pctoreg), .illegal(illegal), .instret(instret)
  );

  assign obs = {memreq, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
                alucontrol, signext, shiftl16, regwrite, regdst, memtoreg,
                pctoreg, illegal};

  typedef struct {
    string            tag;
    logic [20:0]      val;
    logic [20:0]      mask;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [20:0] ev, em;
  int          ret_now = 0;
  int          tests   = 0;
  int          fails   = 0;

  // Strobes and illegal are always checked; selects only where stated.
  task automatic clr();
    ev = '0;
    em = '0;
    em[B_MEMREQ] = 1'b1; em[B_MEMWRITE] = 1'b1; em[B_IRWRITE] = 1'b1;
    em[B_PCEN] = 1'b1;   em[B_REGWRITE] = 1'b1; em[B_ILLEGAL] = 1'b1;
  endtask

  task automatic f(input int lsb, input int w, input int val);
    for (int i = 0; i < w; i++) begin
      ev[lsb+i] = val[i];
      em[lsb+i] = 1'b1;
    end
  endtask

  task automatic cyc(input string tag, input logic mr);
    exp_t e;
    memready = mr;
    sb.push_back('{tag, ev, em, ret_now[CNT_W-1:0]});
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    assert ((obs & e.mask) === (e.val & e.mask)) else begin
      fails++;
      $error("FAIL %s outputs: got %h expected %h (mask %h)", e.tag, obs & e.mask,
             e.val & e.mask, e.mask);
    end
    tests++;
    assert (instret === e.ret) else begin
      fails++;
      $error("FAIL %s instret: got %0d expected %0d", e.tag, instret, e.ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic x_fetch(input int mr);
    clr(); f(B_MEMREQ,1,1); f(B_IORD,1,0); f(B_ALUSRCA,1,0); f(B_ALUSRCB,2,1);
    f(B_ALUCTL,4,4'b0010); f(B_PCSRC,2,0); f(B_IRWRITE,1,mr); f(B_PCEN,1,mr);
  endtask
  task automatic x_decode();
    clr(); f(B_ALUSRCA,1,0); f(B_ALUSRCB,2,3); f(B_SIGNEXT,1,1); f(B_ALUCTL,4,4'b0010);
  endtask
  task automatic x_memadr();
    clr(); f(B_ALUSRCA,1,1); f(B_ALUSRCB,2,2); f(B_SIGNEXT,1,1); f(B_ALUCTL,4,4'b0010);
  endtask
  task automatic x_memrd();
    clr(); f(B_MEMREQ,1,1); f(B_IORD,1,1);
  endtask
  task automatic x_memwb();
    clr(); f(B_REGWRITE,1,1); f(B_REGDST,1,0); f(B_MEMTOREG,1,1);
  endtask
  task automatic x_memwr();
    clr(); f(B_MEMREQ,1,1); f(B_MEMWRITE,1,1); f(B_IORD,1,1);
  endtask
  task automatic x_rex(input int ctl);
    clr(); f(B_ALUSRCA,1,1); f(B_ALUSRCB,2,0); f(B_ALUCTL,4,ctl);
  endtask
  task automatic x_rwb(input int ctl);
    clr(); f(B_REGWRITE,1,1); f(B_REGDST,1,1); f(B_MEMTOREG,1,0); f(B_ALUCTL,4,ctl);
  endtask
  task automatic x_imm(input int ctl, input int sx, input int sh);
    clr(); f(B_ALUSRCA,1,1); f(B_ALUSRCB,2,2); f(B_ALUCTL,4,ctl);
    f(B_SIGNEXT,1,sx); f(B_SHIFTL16,1,sh);
  endtask
  task automatic x_iwb();
    clr(); f(B_REGWRITE,1,1); f(B_REGDST,1,0); f(B_MEMTOREG,1,0);
  endtask

  task automatic fd(input logic [5:0] o, input logic [5:0] fn);
    op = o; funct = fn;
    x_fetch(1); cyc("fetch", 1'b1);
    x_decode(); cyc("decode", 1'b1);
  endtask

  task automatic do_rtype(input logic [5:0] fn, input int ctl);
    fd(6'h00, fn);
    x_rex(ctl); cyc("rtype_ex", 1'b1);
    x_rwb(ctl); cyc("rtype_wb", 1'b1);
    ret_now++;
  endtask

  logic [5:0] r_fn  [7] = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
  int         r_ctl [7] = '{4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
  logic [5:0] i_op  [6] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0F};
  int         i_ctl [6] = '{4'b0010, 4'b0010, 4'b0111, 4'b1111, 4'b0001, 4'b0010};
  int         i_sx  [6] = '{1, 1, 1, 1, 0, 0};
  int         i_sh  [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; zero = 1'b0; memready = 1'b0; op = '0; funct = '0;
    @(posedge clk); #1;
    clr(); cyc("reset", 1'b1);
    reset = 1'b0;

    do_rtype(6'h20, 4'b0010);
    for (int i = 0; i < 7; i++) do_rtype(r_fn[i], r_ctl[i]);

    // lw: three wait cycles in MEMRD, eight cycles total
    fd(6'h23, 6'h00);
    x_memadr(); cyc("lw_memadr", 1'b1);
    x_memrd();
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0);
    cyc("lw_memrd", 1'b1);
    x_memwb(); cyc("lw_memwb", 1'b1);
    ret_now++;

    // sw: one wait in FETCH and one in MEMWR
    op = 6'h2B;
    x_fetch(0); cyc("sw_fetch_wait", 1'b0);
    x_fetch(1); cyc("sw_fetch", 1'b1);
    x_decode(); cyc("sw_decode", 1'b1);
    x_memadr(); cyc("sw_memadr", 1'b1);
    x_memwr(); cyc("sw_memwr_wait", 1'b0);
    cyc("sw_memwr", 1'b1);
    ret_now++;

    for (int i = 0; i < 6; i++) begin
      fd(i_op[i], 6'h00);
      x_imm(i_ctl[i], i_sx[i], i_sh[i]); cyc("imm_ex", 1'b1);
      x_iwb(); cyc("imm_wb", 1'b1);
      ret_now++;
    end

    // branches: {op, zero, expected pcen}
    for (int i = 0; i < 4; i++) begin
      zero = i[0];
      fd((i < 2) ? 6'h04 : 6'h05, 6'h00);
      clr(); f(B_ALUSRCA,1,1); f(B_ALUSRCB,2,0); f(B_ALUCTL,4,4'b0110);
      f(B_PCSRC,2,1); f(B_PCEN,1,(i < 2) ? i[0] : ~i[0]);
      cyc((i < 2) ? "beq" : "bne", 1'b1);
      ret_now++;
    end
    zero = 1'b0;

    fd(6'h02, 6'h00);
    clr(); f(B_PCSRC,2,2); f(B_PCEN,1,1); cyc("j", 1'b1);
    ret_now++;
    fd(6'h03, 6'h00);
    clr(); f(B_PCSRC,2,2); f(B_PCEN,1,1); f(B_REGWRITE,1,1); f(B_PCTOREG,1,1);
    cyc("jal", 1'b1);
    ret_now++;
    fd(6'h00, 6'h08);
    clr(); f(B_PCSRC,2,3); f(B_PCEN,1,1); cyc("jr", 1'b1);
    ret_now++;

    // reset while a store waits for memready
    fd(6'h2B, 6'h00);
    x_memadr(); cyc("sw2_memadr", 1'b1);
    x_memwr(); cyc("sw2_memwr_wait", 1'b0);
    reset = 1'b1;
    clr(); cyc("reset_in_memwr", 1'b0);
    reset = 1'b0;
    ret_now = 0;
    x_fetch(0); cyc("after_reset_fetch", 1'b0);

    // undefined opcode traps; memory idle and counter frozen while trapped
    op = 6'h3F;
    x_fetch(1); cyc("ill_fetch", 1'b1);
    x_decode(); cyc("ill_decode", 1'b1);
    clr(); f(B_ILLEGAL,1,1);
    for (int i = 0; i < 4; i++) cyc("trap", i[0]);
    reset = 1'b1;
    clr(); em[B_ILLEGAL] = 1'b0; cyc("reset_trap", 1'b1);
    reset = 1'b0;

    // undefined R-type funct also traps
    op = 6'h00; funct = 6'h3F;
    x_fetch(1); cyc("illfn_fetch", 1'b1);
    x_decode(); cyc("illfn_decode", 1'b1);
    clr(); f(B_ILLEGAL,1,1);
    cyc("illfn_trap", 1'b1);
    cyc("illfn_trap", 1'b0);
    reset = 1'b1;
    clr(); em[B_ILLEGAL] = 1'b0; cyc("reset_illfn", 1'b1);
    reset = 1'b0;

    do_rtype(6'h20, 4'b0010);
    x_fetch(0); cyc("final_fetch", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
